// File: rtl/apb_spi_slave.sv
// SPI mode-0 slave (MSB first) oversampled in the APB clock domain.
// Single-entry RX/TX holding registers with sticky status flags, reached through a zero-wait APB register file.
module apb_spi_slave #(
  parameter int WORD_W = 32
) (
  input  logic        pclk_i,
  input  logic        prstn_i,
  input  logic [31:0] paddr_i,
  input  logic        pwrite_i,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic [31:0] pwdata_i,
  output logic [31:0] prdata_o,
  output logic        pready_o,
  input  logic        sck_i,
  input  logic        nss_i,
  input  logic        mosi_i,
  output logic        miso_o,
  output logic        miso_oe_o
);

  localparam int CNT_W = $clog2(WORD_W + 1);

  logic              sck_p0, sck_p1, sck_p2;
  logic              nss_p0, nss_p1, nss_p2;
  logic              mosi_p0, mosi_p1;
  logic              sck_rise, sck_fall, nss_rise, nss_fall, active;
  logic [CNT_W-1:0]  bit_cnt;
  logic [WORD_W-1:0] rx_shift, rx_hold, rx_word, tx_hold, tx_shift;
  logic              rx_valid, tx_full, rx_overrun, tx_underrun, reload;
  logic              access, wr_tx, wr_stat, rd_rx;
  logic              word_done, load_tx, shift_tx;
  logic [1:0]        reg_sel;
  logic              unused;

  assign unused    = ^{paddr_i[31:4], paddr_i[1:0], pwdata_i};
  assign pready_o  = 1'b1;
  assign miso_o    = tx_shift[WORD_W-1];
  assign miso_oe_o = ~nss_p1;

  assign reg_sel = paddr_i[3:2];
  assign access  = psel_i & penable_i;
  assign wr_tx   = access & pwrite_i & (reg_sel == 2'd0);
  assign rd_rx   = access & ~pwrite_i & (reg_sel == 2'd1);
  assign wr_stat = access & pwrite_i & (reg_sel == 2'd2);

  assign sck_rise = sck_p1 & ~sck_p2;
  assign sck_fall = ~sck_p1 & sck_p2;
  assign nss_rise = nss_p1 & ~nss_p2;
  assign nss_fall = ~nss_p1 & nss_p2;
  assign active   = ~nss_p1;

  assign rx_word   = {rx_shift[WORD_W-2:0], mosi_p1};
  assign word_done = sck_rise & active & (bit_cnt == CNT_W'(WORD_W - 1));
  // A frame end driven together with the last sck fall deasserts active, so no trailing reload happens.
  assign load_tx   = nss_fall | (sck_fall & active & reload);
  assign shift_tx  = sck_fall & active & ~reload & (bit_cnt != '0);

  // Stage p0/p1: metastability filter; p2: previous value for edge detection
  always_ff @(posedge pclk_i or negedge prstn_i) begin
    if (!prstn_i) begin
      sck_p0  <= 1'b0;
      sck_p1  <= 1'b0;
      sck_p2  <= 1'b0;
      nss_p0  <= 1'b1;
      nss_p1  <= 1'b1;
      nss_p2  <= 1'b1;
      mosi_p0 <= 1'b0;
      mosi_p1 <= 1'b0;
    end else begin
      sck_p0  <= sck_i;
      sck_p1  <= sck_p0;
      sck_p2  <= sck_p1;
      nss_p0  <= nss_i;
      nss_p1  <= nss_p0;
      nss_p2  <= nss_p1;
      mosi_p0 <= mosi_i;
      mosi_p1 <= mosi_p0;
    end
  end

  always_ff @(posedge pclk_i or negedge prstn_i) begin
    if (!prstn_i) begin
      bit_cnt  <= '0;
      reload   <= 1'b0;
      rx_shift <= '0;
    end else if (nss_rise) begin
      bit_cnt <= '0;
      reload  <= 1'b0;
    end else if (nss_fall) begin
      bit_cnt <= '0;
    end else if (sck_rise && active) begin
      rx_shift <= rx_word;
      if (word_done) begin
        bit_cnt <= '0;
        reload  <= 1'b1;
      end else begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
    end else if (sck_fall && active && reload) begin
      reload <= 1'b0;
    end
  end

  // A load consumes the old tx_hold; a concurrent write then refills it.
  always_ff @(posedge pclk_i or negedge prstn_i) begin
    if (!prstn_i) begin
      tx_hold     <= '0;
      tx_shift    <= '0;
      tx_full     <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      if (load_tx)       tx_shift <= tx_full ? tx_hold : '0;
      else if (shift_tx) tx_shift <= {tx_shift[WORD_W-2:0], 1'b0};

      if (wr_tx)        tx_hold <= pwdata_i[WORD_W-1:0];

      if (wr_tx)        tx_full <= 1'b1;
      else if (load_tx) tx_full <= 1'b0;

      if (load_tx && !tx_full)        tx_underrun <= 1'b1;
      else if (wr_stat && pwdata_i[3]) tx_underrun <= 1'b0;
    end
  end

  always_ff @(posedge pclk_i or negedge prstn_i) begin
    if (!prstn_i) begin
      rx_hold    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      if (word_done && (!rx_valid || rd_rx)) rx_hold <= rx_word;

      if (word_done)  rx_valid <= 1'b1;
      else if (rd_rx) rx_valid <= 1'b0;

      if (word_done && rx_valid && !rd_rx) rx_overrun <= 1'b1;
      else if (wr_stat && pwdata_i[2])     rx_overrun <= 1'b0;
    end
  end

  always_comb begin
    prdata_o = '0;
    if (psel_i && !pwrite_i) begin
      case (reg_sel)
        2'd1:    prdata_o[WORD_W-1:0] = rx_hold;
        2'd2:    prdata_o[4:0] = {~nss_p1, tx_underrun, rx_overrun, tx_full, rx_valid};
        default: prdata_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_spi_slave.sv
// Bench for apb_spi_slave: acts as SPI master and APB host, predicting results with a word-level
// model of the holding registers and flags.
module tb_apb_spi_slave;

  logic        pclk = 1'b0;
  logic        prstn;
  logic [31:0] paddr, pwdata, prdata;
  logic        pwrite, psel, penable, pready;
  logic        sck, nss, mosi, miso, miso_oe;

  int n_checks = 0;
  int n_errors = 0;

  // Word-level reference state
  logic [31:0] m_tx_hold, m_rx_hold;
  logic        m_tx_full, m_rx_valid, m_ovr, m_udr;

  apb_spi_slave #(.WORD_W(32)) dut (
    .pclk_i(pclk), .prstn_i(prstn), .paddr_i(paddr), .pwrite_i(pwrite),
    .psel_i(psel), .penable_i(penable), .pwdata_i(pwdata), .prdata_o(prdata),
    .pready_o(pready), .sck_i(sck), .nss_i(nss), .mosi_i(mosi),
    .miso_o(miso), .miso_oe_o(miso_oe)
  );

  always #5 pclk = ~pclk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  function automatic logic [31:0] m_status();
    return {27'b0, 1'b0, m_udr, m_ovr, m_tx_full, m_rx_valid};
  endfunction

  task automatic m_reset();
    m_tx_hold = '0; m_rx_hold = '0;
    m_tx_full = 0; m_rx_valid = 0; m_ovr = 0; m_udr = 0;
  endtask

  task automatic m_load(output logic [31:0] w);
    if (m_tx_full) begin
      w = m_tx_hold;
      m_tx_full = 0;
    end else begin
      w = '0;
      m_udr = 1;
    end
  endtask

  task automatic m_complete(input logic [31:0] w);
    if (!m_rx_valid) begin
      m_rx_hold = w;
      m_rx_valid = 1;
    end else begin
      m_ovr = 1;
    end
  endtask

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    paddr = a; pwdata = d; pwrite = 1; psel = 1; penable = 0;
    wait_clk(1);
    penable = 1;
    wait_clk(1);
    psel = 0; penable = 0; pwrite = 0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
    paddr = a; pwrite = 0; psel = 1; penable = 0;
    wait_clk(1);
    penable = 1;
    #3 d = prdata;
    wait_clk(1);
    psel = 0; penable = 0;
  endtask

  task automatic tx_write(input logic [31:0] d);
    apb_write(32'h0, d);
    m_tx_hold = d;
    m_tx_full = 1;
  endtask

  task automatic clr_flags(input logic [31:0] d);
    apb_write(32'h8, d);
    if (d[2]) m_ovr = 0;
    if (d[3]) m_udr = 0;
  endtask

  task automatic rd_rx(output logic [31:0] got);
    apb_read(32'h4, got);
    check("rxdata", got, m_rx_hold);
    m_rx_valid = 0;
  endtask

  task automatic chk_status(input string tag);
    logic [31:0] s;
    apb_read(32'h8, s);
    check(tag, s, m_status());
  endtask

  // Mode 0 master: data set while sck low, slave sampled just before sck rises.
  task automatic spi_shift(input logic [31:0] w, input int nbits, input bit end_frame,
                           output logic [31:0] got);
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = w[31-i];
      wait_clk(4);
      got[31-i] = miso;
      sck = 1;
      wait_clk(4);
      sck = 0;
      if (end_frame && i == nbits - 1) nss = 1;
    end
  endtask

  task automatic do_frame(input int nw, input logic [31:0] w0, input logic [31:0] w1,
                          input bit mid, input logic [31:0] mid_data);
    logic [31:0] exp, got, w, s;
    nss = 0;
    wait_clk(4);
    check("miso_oe", {31'b0, miso_oe}, 32'h1);
    for (int k = 0; k < nw; k++) begin
      w = (k == 0) ? w0 : w1;
      m_load(exp);
      if (k == 0 && mid) begin
        fork
          spi_shift(w, 32, (k == nw - 1), got);
          begin
            wait_clk(40);
            tx_write(mid_data);
            apb_read(32'h8, s);
            check("busy_full", s & 32'h12, 32'h12);
          end
        join
      end else begin
        spi_shift(w, 32, (k == nw - 1), got);
      end
      check("miso_word", got, exp);
      m_complete(w);
    end
    wait_clk(8);
  endtask

  initial begin
    logic [31:0] d, exp, got, r0, r1;
    int nwr, nw;
    prstn = 0; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
    sck = 0; nss = 1; mosi = 0;
    m_reset();
    wait_clk(3);
    check("rst_miso", {31'b0, miso}, 32'h0);
    check("rst_oe", {31'b0, miso_oe}, 32'h0);
    check("rst_prdata", prdata, 32'h0);
    check("rst_pready", {31'b0, pready}, 32'h1);
    prstn = 1;
    wait_clk(2);
    chk_status("status_reset");
    rd_rx(d);
    apb_read(32'hC, d);
    check("reg_c", d, 32'h0);
    apb_write(32'hC, 32'hFFFF_FFFF);
    chk_status("status_after_c_write");

    // Basic exchange
    tx_write(32'hA5A5_0F0F);
    apb_read(32'h0, d);
    check("txdata_reads_zero", d, 32'h0);
    chk_status("status_tx_full");
    do_frame(1, 32'h1234_5678, 32'h0, 0, 32'h0);
    chk_status("status_basic_pre");
    rd_rx(d);
    check("basic_rx", d, 32'h1234_5678);
    chk_status("status_basic_post");

    // Underrun
    do_frame(1, $urandom, 32'h0, 0, 32'h0);
    apb_read(32'h8, d);
    check("udr_flag", {31'b0, d[3]}, 32'h1);
    clr_flags(32'h8);
    chk_status("status_udr_cleared");

    // Overrun
    rd_rx(d);
    r0 = $urandom; r1 = $urandom;
    do_frame(2, r0, r1, 0, 32'h0);
    chk_status("status_ovr");
    rd_rx(d);
    check("ovr_first_word", d, r0);
    clr_flags(32'hC);

    // Continuous frames with a refill during the first word
    tx_write(32'h1111_1111);
    do_frame(2, $urandom, $urandom, 1, 32'h2222_2222);
    apb_read(32'h8, d);
    check("cont_no_udr", {31'b0, d[3]}, 32'h0);
    chk_status("status_cont");
    rd_rx(d);
    clr_flags(32'hC);

    // Abort after 13 bits
    tx_write($urandom);
    nss = 0;
    wait_clk(4);
    m_load(exp);
    spi_shift($urandom, 13, 1, got);
    check("abort_miso", got, exp & 32'hFFF8_0000);
    wait_clk(8);
    chk_status("status_abort");
    do_frame(1, 32'hDEAD_BEEF, 32'h0, 0, 32'h0);
    apb_read(32'h8, d);
    check("abort_no_ovr", {31'b0, d[2]}, 32'h0);
    rd_rx(d);
    check("abort_rx", d, 32'hDEAD_BEEF);
    clr_flags(32'hC);

    // Reset mid-word
    tx_write(32'h0F0F_F0F0);
    nss = 0;
    wait_clk(4);
    m_load(exp);
    spi_shift($urandom, 10, 0, got);
    check("pre_rst_miso", got, exp & 32'hFFC0_0000);
    prstn = 0;
    #1;
    check("midrst_miso", {31'b0, miso}, 32'h0);
    check("midrst_oe", {31'b0, miso_oe}, 32'h0);
    check("midrst_prdata", prdata, 32'h0);
    check("midrst_pready", {31'b0, pready}, 32'h1);
    nss = 1;
    wait_clk(3);
    prstn = 1;
    m_reset();
    wait_clk(2);
    chk_status("status_post_rst");
    rd_rx(d);
    do_frame(1, $urandom, 32'h0, 0, 32'h0);
    rd_rx(d);
    clr_flags(32'hC);
    tx_write($urandom);
    do_frame(1, $urandom, 32'h0, 0, 32'h0);
    chk_status("status_post_rst_frame");
    rd_rx(d);

    // Randomised traffic
    for (int it = 0; it < 8; it++) begin
      nwr = $urandom_range(0, 2);
      for (int j = 0; j < nwr; j++) tx_write($urandom);
      nw = $urandom_range(1, 2);
      do_frame(nw, $urandom, $urandom, 0, 32'h0);
      if ($urandom_range(0, 1) == 1) begin
        chk_status("rand_status_pre");
        rd_rx(d);
      end
      if ($urandom_range(0, 1) == 1) clr_flags($urandom & 32'hC);
      chk_status("rand_status");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/apb_spi_slave.md
# apb_spi_slave

APB-programmable SPI slave: the responder-side counterpart to the team's APB SPI master. It oversamples an external SPI bus (mode 0, MSB first) in the `pclk_i` domain, deserialises MOSI into 32-bit words and serialises a CPU-supplied word onto MISO. Software reaches it through a zero-wait-state APB register file with single-entry RX/TX holding registers and status flags. It sits beside the master in the same APB subsystem, typically as a loopback or board-link endpoint.

## Interface
- `WORD_W`, 32: bits per SPI word (8..32).
- `pclk_i`  in  1  APB/system clock; all logic is on the rising edge.
- `prstn_i`  in  1  asynchronous active-low reset.
- `paddr_i`  in  32  APB address; only bits [3:2] are decoded.
- `pwrite_i`  in  1  1 = write, 0 = read.
- `psel_i`  in  1  APB select.
- `penable_i`  in  1  APB access phase.
- `pwdata_i`  in  32  APB write data.
- `prdata_o`  out  32  APB read data.
- `pready_o`  out  1  tied to 1; no wait states.
- `sck_i`  in  1  SPI clock from master; asynchronous.
- `nss_i`  in  1  SPI chip select, active low; asynchronous.
- `mosi_i`  in  1  SPI data from master; asynchronous.
- `miso_o`  out  1  SPI data to master.
- `miso_oe_o`  out  1  MISO output enable; equals the synchronised `~nss`.

## Operation
- Registers (access = `psel_i & penable_i`):
  - 0x0 TXDATA (W): loads tx_hold[WORD_W-1:0] and sets tx_full.
  - 0x4 RXDATA (R): returns rx_hold. The access clears rx_valid.
  - 0x8 STATUS (R): bit0 rx_valid, bit1 tx_full, bit2 rx_overrun, bit3 tx_underrun, bit4 busy (nss low). Writing 1 to bit2 or bit3 clears that flag.
  - 0xC: reads 0; writes ignored.
- `prdata_o` is combinational. It is valid when `psel_i & ~pwrite_i`; otherwise it is 0. Unused upper bits read as 0.
- `sck_i`, `nss_i` and `mosi_i` each pass through a 2-FF synchroniser. One more flop on sck and nss gives edge detection (rise/fall pulses).
- nss falling edge:
  - bit_cnt is set to 0.
  - The TX shifter is loaded from tx_hold if tx_full; tx_full is then cleared. Otherwise the shifter is loaded with 0 and tx_underrun is set.
- sck rising edge (nss low): rx_shift <= {rx_shift[WORD_W-2:0], mosi_sync} and bit_cnt increments.
- bit_cnt reaching WORD_W (word complete):
  - If rx_valid is clear, or a RXDATA read happens in the same cycle: rx_hold <= new word and rx_valid is set.
  - Otherwise the new word is dropped, rx_hold is kept and rx_overrun is set.
  - bit_cnt returns to 0 and the reload flag is set.
- sck falling edge (nss low):
  - If the reload flag is set, the TX shifter reloads exactly as on an nss fall and the reload flag clears.
  - Else if bit_cnt != 0, the TX shifter shifts left by one.
- `miso_o` is always the TX shifter MSB.
- nss rising edge mid-word: the partial word is discarded, bit_cnt goes to 0, the reload flag clears and no flag changes.
- A TXDATA write while tx_full overwrites tx_hold; there is no error.
- A TXDATA write in the same cycle as a shifter load: the load takes the old tx_hold, then the write sets tx_full with the new value.
- Set and clear of a flag in the same cycle: set wins.

## Timing
- Reset values:
  - tx_hold, rx_hold, rx_shift, TX shifter and bit_cnt: 0.
  - All flags and the reload flag: 0.
  - Synchronisers: sck 0, nss 1, mosi 0.
  - Outputs: `miso_o` 0, `miso_oe_o` 0, `prdata_o` 0, `pready_o` 1.
- Input-to-action latency is 3 pclk cycles after an edge on the pin.
- `miso_o` updates 3 pclk after an sck fall or nss fall.
- Constraints on the master:
  - sck high and low phases ≥ 4 pclk each, i.e. sck ≤ pclk/8.
  - nss fall to first sck rise ≥ 4 pclk.
- rx_valid rises in the cycle after the WORD_W-th sync rising edge is detected.
- APB: every access completes in one access-phase cycle. Register effects are visible on the next cycle.
- Asserting reset mid-transfer aborts immediately. After release, the slave waits for the next nss fall before participating.

## Test plan
- Basic exchange:
  - Stimulus: write TXDATA=0xA5A5_0F0F, then the master sends 0x1234_5678 at sck = pclk/8.
  - Response: MISO carries 0xA5A5_0F0F MSB first; RXDATA=0x1234_5678; STATUS bit0 is 1 before the read and 0 after.
- Underrun:
  - Stimulus: no TXDATA write, then a transfer.
  - Response: MISO is all 0; STATUS bit3 = 1; writing 0x8 to STATUS clears it.
- Overrun:
  - Stimulus: two words sent back-to-back without reading RXDATA.
  - Response: RXDATA returns the first word; bit2 = 1.
- Continuous frames:
  - Stimulus: TXDATA=0x1111_1111, master sends word 1; TXDATA=0x2222_2222 written before the 32nd rise; master sends word 2; all under a single nss low.
  - Response: MISO sends both words in order; no underrun.
- Abort:
  - Stimulus: nss rises after 13 bits, then a full word 0xDEAD_BEEF is sent.
  - Response: RXDATA=0xDEAD_BEEF; no overrun; the partial word is never visible.
- Reset:
  - Stimulus: prstn_i asserted mid-word.
  - Response: all outputs and registers return to their reset values; the next frame after an nss fall is received correctly.
